hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline hazard and control unit that drives the hold/kill/flush inputs of the IF/ID, ID/EX and EX/MEM pipeline registers. It detects load-use hazards, holds the pipeline during multi-cycle data-memory accesses, flushes wrong-path instructions on an EX-stage redirect, and drains the pipeline on an EX-stage halt or trap. It sits beside the decode stage and takes operand usage from ID, producer information from EX, and the memory handshake from MEM.

## Interface
- DRAIN_CYCLES, 2, cycles spent in DRAIN before HALTED (MEM+WB depth); legal range 1..15

- i_clk  in  1  clock, rising edge
- i_rst_n  in  1  asynchronous active-low reset
- i_id_valid  in  1  ID holds a real instruction
- i_id_rs1_addr / i_id_rs2_addr  in  5  ID source registers
- i_id_rs1_used / i_id_rs2_used  in  1  ID instruction reads rs1 / rs2
- i_ex_valid  in  1  EX holds a real instruction
- i_ex_mem_read  in  1  EX instruction is a load
- i_ex_rd_addr  in  5  EX destination register
- i_ex_redirect  in  1  EX resolved a mispredicted branch or a jump
- i_ex_halt / i_ex_trap  in  1  EX instruction is a halt / a trap
- i_mem_req  in  1  MEM stage has a valid data-memory access this cycle
- i_mem_ack  in  1  data memory completes the access this cycle
- o_if_stall  out  1  hold the PC and IF/ID
- o_ifid_flush  out  1  clear IF/ID at the next edge
- o_idex_stall_thru  out  1  ID/EX holds its contents
- o_idex_stall_kill  out  1  ID/EX loads a bubble
- o_idex_flush  out  1  clear ID/EX at the next edge
- o_exmem_stall  out  1  hold EX/MEM
- o_halted  out  1  pipeline drained after halt or trap; sticky
- o_stall_cycles  out  32  count of stalled front-end cycles

## Operation
- FSM states are RUN, MEM_WAIT, DRAIN and HALTED. All control outputs are Mealy, decoded from the registered state and the current inputs.
- Load-use hazard: `lu = i_id_valid & i_ex_valid & i_ex_mem_read & (i_ex_rd_addr != 0) & ((i_id_rs1_used & rs1 == rd) | (i_id_rs2_used & rs2 == rd))`.
- RUN applies these cases in priority order; the first matching case wins.
  1. `i_mem_req & !i_mem_ack`: assert o_if_stall, o_idex_stall_thru and o_exmem_stall. Next state is MEM_WAIT.
  2. `i_ex_valid & (i_ex_halt | i_ex_trap)`: assert o_if_stall, o_ifid_flush and o_idex_flush. Load the drain counter with DRAIN_CYCLES-1. Next state is DRAIN.
  3. `i_ex_valid & i_ex_redirect`: assert o_ifid_flush and o_idex_flush. No stall. Stay in RUN.
  4. `lu`: assert o_if_stall and o_idex_stall_kill. Stay in RUN.
  5. Otherwise all control outputs are 0.
- MEM_WAIT:
  - While `!i_mem_ack`, the outputs match RUN case 1.
  - In the cycle `i_mem_ack` = 1, all control outputs are 0 and the next state is RUN.
  - Redirect, halt and load-use are ignored in MEM_WAIT. The stalled EX instruction re-presents them in RUN.
- DRAIN:
  - Assert o_if_stall, o_ifid_flush and o_idex_flush every cycle.
  - Decrement the counter. When it reaches 0, the next state is HALTED.
  - i_mem_req/i_mem_ack are ignored in DRAIN; MEM completes on its own.
- HALTED:
  - o_halted = 1, plus o_if_stall, o_ifid_flush and o_idex_flush.
  - The only exit is reset.
- o_idex_stall_thru and o_idex_stall_kill are never asserted together.
- o_idex_flush wins over the stalls in the ID/EX register, so DRAIN never asserts a stall alongside the flush.

## Timing
- Detection to control output has zero-cycle latency (combinational). The effect lands at the next rising edge.
- Load-use costs exactly 1 bubble; the consumer re-evaluates the next cycle with the load in MEM, so lu = 0.
- A memory access acked in the request cycle costs 0 stall cycles. Each additional cycle without ack costs 1 stall cycle.
- The halt/trap edge is edge 0. The FSM spends DRAIN_CYCLES cycles in DRAIN, and o_halted rises DRAIN_CYCLES cycles after edge 0.
- Reset asynchronously forces:
  - state to RUN and the drain counter to 0;
  - o_halted = 0 and o_stall_cycles = 0;
  - every control output to 0 while i_rst_n = 0.
- Reset may land mid-MEM_WAIT or mid-DRAIN; the block restarts in RUN with no residual stall.

## Configuration
- HAZARD_PERF_CNT_EN defined:
  - o_stall_cycles increments by 1 on each rising edge where o_if_stall = 1 and the state is RUN or MEM_WAIT.
  - The count wraps from 0xFFFFFFFF to 0.
- HAZARD_PERF_CNT_EN undefined: no counter register exists and o_stall_cycles is tied to 32'h0.

## Test plan
- Load-use: EX = `lw x5` (valid, rd=5), ID uses rs1=5 -> one cycle with o_if_stall=1 and o_idex_stall_kill=1, then all control outputs 0. The same case with rd=0 -> no stall.
- Memory wait: i_mem_req=1 with i_mem_ack=0 for 3 cycles, then 1 -> o_idex_stall_thru=o_exmem_stall=1 for 3 cycles, 0 in the ack cycle. With the counter macro on, o_stall_cycles=3.
- Redirect racing a load-use: i_ex_redirect=1 with lu=1 in the same cycle -> o_ifid_flush=o_idex_flush=1, o_idex_stall_kill=0, o_if_stall=0.
- Halt with DRAIN_CYCLES=2: i_ex_halt=1, i_ex_valid=1 -> 2 cycles in DRAIN with flushes, then o_halted=1 and sticky. A later i_ex_redirect changes nothing.
- Halt racing a memory stall: halt and `i_mem_req & !i_mem_ack` together -> MEM_WAIT first; DRAIN is entered only after the ack.
- Async reset mid-DRAIN -> all outputs 0 immediately, o_stall_cycles=0, normal RUN behaviour after release.

Source files
------------

// File: rtl/hazard_ctrl_if.sv
// Handshake bundle between the pipeline datapath and hazard_ctrl.
// The datapath side uses the master modport, the hazard unit the slave modport.
interface hazard_ctrl_if;
  logic        i_id_valid;
  logic [4:0]  i_id_rs1_addr;
  logic [4:0]  i_id_rs2_addr;
  logic        i_id_rs1_used;
  logic        i_id_rs2_used;
  logic        i_ex_valid;
  logic        i_ex_mem_read;
  logic [4:0]  i_ex_rd_addr;
  logic        i_ex_redirect;
  logic        i_ex_halt;
  logic        i_ex_trap;
  logic        i_mem_req;
  logic        i_mem_ack;
  logic        o_if_stall;
  logic        o_ifid_flush;
  logic        o_idex_stall_thru;
  logic        o_idex_stall_kill;
  logic        o_idex_flush;
  logic        o_exmem_stall;
  logic        o_halted;
  logic [31:0] o_stall_cycles;

  modport master (
    output i_id_valid, i_id_rs1_addr, i_id_rs2_addr, i_id_rs1_used, i_id_rs2_used,
    output i_ex_valid, i_ex_mem_read, i_ex_rd_addr, i_ex_redirect, i_ex_halt, i_ex_trap,
    output i_mem_req, i_mem_ack,
    input  o_if_stall, o_ifid_flush, o_idex_stall_thru, o_idex_stall_kill,
    input  o_idex_flush, o_exmem_stall, o_halted, o_stall_cycles
  );

  modport slave (
    input  i_id_valid, i_id_rs1_addr, i_id_rs2_addr, i_id_rs1_used, i_id_rs2_used,
    input  i_ex_valid, i_ex_mem_read, i_ex_rd_addr, i_ex_redirect, i_ex_halt, i_ex_trap,
    input  i_mem_req, i_mem_ack,
    output o_if_stall, o_ifid_flush, o_idex_stall_thru, o_idex_stall_kill,
    output o_idex_flush, o_exmem_stall, o_halted, o_stall_cycles
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard/control unit: load-use bubbles, memory-wait holds, redirect flushes, halt drain.
// Define HAZARD_PERF_CNT_EN to build the stalled-front-end cycle counter on o_stall_cycles.
module hazard_ctrl #(
  parameter int DRAIN_CYCLES = 2
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  hazard_ctrl_if.slave bus
);

  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_MEM_WAIT = 2'd1;
  localparam logic [1:0] ST_DRAIN    = 2'd2;
  localparam logic [1:0] ST_HALTED   = 2'd3;

  localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);

  logic [1:0] state_reg, state_next;
  logic [3:0] drain_cnt_reg, drain_cnt_next;

  logic load_use, mem_busy, ex_stop, ex_redir;
  logic if_stall, ifid_flush, idex_stall_thru, idex_stall_kill, idex_flush, exmem_stall;

  always_comb begin
    load_use = bus.i_id_valid & bus.i_ex_valid & bus.i_ex_mem_read &
               (bus.i_ex_rd_addr != 5'd0) &
               ((bus.i_id_rs1_used & (bus.i_id_rs1_addr == bus.i_ex_rd_addr)) |
                (bus.i_id_rs2_used & (bus.i_id_rs2_addr == bus.i_ex_rd_addr)));
    mem_busy = bus.i_mem_req & ~bus.i_mem_ack;
    ex_stop  = bus.i_ex_valid & (bus.i_ex_halt | bus.i_ex_trap);
    ex_redir = bus.i_ex_valid & bus.i_ex_redirect;
  end

  always_comb begin
    state_next      = state_reg;
    drain_cnt_next  = drain_cnt_reg;
    if_stall        = 1'b0;
    ifid_flush      = 1'b0;
    idex_stall_thru = 1'b0;
    idex_stall_kill = 1'b0;
    idex_flush      = 1'b0;
    exmem_stall     = 1'b0;
    case (state_reg)
      ST_RUN: begin
        if (mem_busy) begin
          if_stall        = 1'b1;
          idex_stall_thru = 1'b1;
          exmem_stall     = 1'b1;
          state_next      = ST_MEM_WAIT;
        end else if (ex_stop) begin
          if_stall       = 1'b1;
          ifid_flush     = 1'b1;
          idex_flush     = 1'b1;
          drain_cnt_next = DRAIN_LOAD;
          state_next     = ST_DRAIN;
        end else if (ex_redir) begin
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
        end else if (load_use) begin
          if_stall        = 1'b1;
          idex_stall_kill = 1'b1;
        end
      end
      // Hazards seen while waiting are re-presented by the held EX instruction once back in RUN.
      ST_MEM_WAIT: begin
        if (!bus.i_mem_ack) begin
          if_stall        = 1'b1;
          idex_stall_thru = 1'b1;
          exmem_stall     = 1'b1;
        end else begin
          state_next = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if_stall   = 1'b1;
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
        if (drain_cnt_reg == 4'd0) begin
          state_next = ST_HALTED;
        end else begin
          drain_cnt_next = drain_cnt_reg - 4'd1;
        end
      end
      default: begin
        if_stall   = 1'b1;
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg     <= ST_RUN;
      drain_cnt_reg <= 4'd0;
    end else begin
      state_reg     <= state_next;
      drain_cnt_reg <= drain_cnt_next;
    end
  end

  // Mealy outputs would otherwise follow the inputs while reset is held.
  assign bus.o_if_stall        = i_rst_n & if_stall;
  assign bus.o_ifid_flush      = i_rst_n & ifid_flush;
  assign bus.o_idex_stall_thru = i_rst_n & idex_stall_thru;
  assign bus.o_idex_stall_kill = i_rst_n & idex_stall_kill;
  assign bus.o_idex_flush      = i_rst_n & idex_flush;
  assign bus.o_exmem_stall     = i_rst_n & exmem_stall;
  assign bus.o_halted          = (state_reg == ST_HALTED);

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt_reg;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      stall_cnt_reg <= 32'd0;
    end else if (if_stall && ((state_reg == ST_RUN) || (state_reg == ST_MEM_WAIT))) begin
      stall_cnt_reg <= stall_cnt_reg + 32'd1;
    end
  end

  assign bus.o_stall_cycles = stall_cnt_reg;
`else
  assign bus.o_stall_cycles = 32'h0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus randomized traffic against a
// cycle-level behavioural model of the hazard rules.
module tb_hazard_ctrl;

  localparam int D = 2;
`ifdef HAZARD_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  // Output vector order: {if_stall, ifid_flush, idex_thru, idex_kill, idex_flush, exmem_stall, halted}
  localparam logic [6:0] O_IDLE   = 7'b0000000;
  localparam logic [6:0] O_MEMSTL = 7'b1010010;
  localparam logic [6:0] O_FLUSH  = 7'b1100100;
  localparam logic [6:0] O_REDIR  = 7'b0100100;
  localparam logic [6:0] O_BUBBLE = 7'b1001000;
  localparam logic [6:0] O_HALTED = 7'b1100101;

  localparam int PH_RUN = 0, PH_WAIT = 1, PH_DRAIN = 2, PH_HALT = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;

  int          m_phase;
  int          m_left;
  int unsigned m_stalls;

  hazard_ctrl_if bus ();

  hazard_ctrl #(.DRAIN_CYCLES(D)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] outs();
    return {bus.o_if_stall, bus.o_ifid_flush, bus.o_idex_stall_thru, bus.o_idex_stall_kill,
            bus.o_idex_flush, bus.o_exmem_stall, bus.o_halted};
  endfunction

  function automatic void model_reset();
    m_phase  = PH_RUN;
    m_left   = 0;
    m_stalls = 0;
  endfunction

  function automatic logic [6:0] model_out();
    logic lu;
    logic [6:0] r;
    r = O_IDLE;
    if (rst_n !== 1'b1) return r;
    lu = bus.i_id_valid && bus.i_ex_valid && bus.i_ex_mem_read && (bus.i_ex_rd_addr != 0) &&
         ((bus.i_id_rs1_used && bus.i_id_rs1_addr == bus.i_ex_rd_addr) ||
          (bus.i_id_rs2_used && bus.i_id_rs2_addr == bus.i_ex_rd_addr));
    case (m_phase)
      PH_RUN: begin
        if (bus.i_mem_req && !bus.i_mem_ack) r = O_MEMSTL;
        else if (bus.i_ex_valid && (bus.i_ex_halt || bus.i_ex_trap)) r = O_FLUSH;
        else if (bus.i_ex_valid && bus.i_ex_redirect) r = O_REDIR;
        else if (lu) r = O_BUBBLE;
      end
      PH_WAIT:  if (!bus.i_mem_ack) r = O_MEMSTL;
      PH_DRAIN: r = O_FLUSH;
      default:  r = O_HALTED;
    endcase
    return r;
  endfunction

  function automatic void model_step();
    logic [6:0] e;
    if (rst_n !== 1'b1) begin
      model_reset();
      return;
    end
    e = model_out();
    if ((m_phase == PH_RUN || m_phase == PH_WAIT) && e[6]) m_stalls++;
    case (m_phase)
      PH_RUN: begin
        if (bus.i_mem_req && !bus.i_mem_ack) m_phase = PH_WAIT;
        else if (bus.i_ex_valid && (bus.i_ex_halt || bus.i_ex_trap)) begin
          m_phase = PH_DRAIN;
          m_left  = D;
        end
      end
      PH_WAIT: if (bus.i_mem_ack) m_phase = PH_RUN;
      PH_DRAIN: begin
        m_left--;
        if (m_left == 0) m_phase = PH_HALT;
      end
      default: ;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic clear_inputs();
    bus.i_id_valid    = 1'b0;
    bus.i_id_rs1_addr = 5'd0;
    bus.i_id_rs2_addr = 5'd0;
    bus.i_id_rs1_used = 1'b0;
    bus.i_id_rs2_used = 1'b0;
    bus.i_ex_valid    = 1'b0;
    bus.i_ex_mem_read = 1'b0;
    bus.i_ex_rd_addr  = 5'd0;
    bus.i_ex_redirect = 1'b0;
    bus.i_ex_halt     = 1'b0;
    bus.i_ex_trap     = 1'b0;
    bus.i_mem_req     = 1'b0;
    bus.i_mem_ack     = 1'b0;
  endtask

  task automatic set_load_use(input logic [4:0] rd);
    bus.i_id_valid    = 1'b1;
    bus.i_id_rs1_addr = 5'd5;
    bus.i_id_rs1_used = 1'b1;
    bus.i_ex_valid    = 1'b1;
    bus.i_ex_mem_read = 1'b1;
    bus.i_ex_rd_addr  = rd;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    #3;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    clear_inputs();
    set_load_use(5'd5);
    rst_n = 1'b0;
    model_reset();
    #2;
    checks++;
    if (outs() !== O_IDLE) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected %b", outs(), O_IDLE);
    end
    checks++;
    if (bus.o_stall_cycles !== 32'd0) begin
      errors++;
      $display("FAIL reset_stall_cycles: got %0d expected 0", bus.o_stall_cycles);
    end
    do_reset();
    clear_inputs();
    $display("test_reset done");
  endtask

  task automatic test_load_use();
    do_reset();
    clear_inputs();
    set_load_use(5'd5);
    #1;
    checks++;
    if (outs() !== O_BUBBLE) begin
      errors++;
      $display("FAIL load_use_bubble: got %b expected %b", outs(), O_BUBBLE);
    end
    tick();
    bus.i_ex_mem_read = 1'b0;
    bus.i_ex_rd_addr  = 5'd9;
    #1;
    checks++;
    if (outs() !== O_IDLE) begin
      errors++;
      $display("FAIL load_use_after: got %b expected %b", outs(), O_IDLE);
    end
    tick();
    set_load_use(5'd0);
    bus.i_id_rs1_addr = 5'd0;
    #1;
    checks++;
    if (outs() !== O_IDLE) begin
      errors++;
      $display("FAIL load_use_x0: got %b expected %b", outs(), O_IDLE);
    end
    tick();
    clear_inputs();
    set_load_use(5'd7);
    bus.i_id_rs1_used = 1'b0;
    bus.i_id_rs2_addr = 5'd7;
    bus.i_id_rs2_used = 1'b1;
    #1;
    checks++;
    if (outs() !== O_BUBBLE) begin
      errors++;
      $display("FAIL load_use_rs2: got %b expected %b", outs(), O_BUBBLE);
    end
    tick();
    clear_inputs();
    $display("test_load_use done");
  endtask

  task automatic test_mem_wait();
    do_reset();
    clear_inputs();
    bus.i_mem_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (outs() !== O_MEMSTL) begin
        errors++;
        $display("FAIL mem_wait_stall%0d: got %b expected %b", i, outs(), O_MEMSTL);
      end
      tick();
    end
    bus.i_mem_ack = 1'b1;
    #1;
    checks++;
    if (outs() !== O_IDLE) begin
      errors++;
      $display("FAIL mem_wait_ack: got %b expected %b", outs(), O_IDLE);
    end
    tick();
    clear_inputs();
    #1;
    checks++;
    if (bus.o_stall_cycles !== (PERF ? 32'd3 : 32'd0)) begin
      errors++;
      $display("FAIL mem_wait_count: got %0d expected %0d", bus.o_stall_cycles, PERF ? 3 : 0);
    end
    bus.i_mem_req = 1'b1;
    bus.i_mem_ack = 1'b1;
    #1;
    checks++;
    if (outs() !== O_IDLE) begin
      errors++;
      $display("FAIL mem_ack_same_cycle: got %b expected %b", outs(), O_IDLE);
    end
    tick();
    clear_inputs();
    $display("test_mem_wait done");
  endtask

  task automatic test_redirect_race();
    do_reset();
    clear_inputs();
    set_load_use(5'd5);
    bus.i_ex_redirect = 1'b1;
    #1;
    checks++;
    if (outs() !== O_REDIR) begin
      errors++;
      $display("FAIL redirect_race: got %b expected %b", outs(), O_REDIR);
    end
    tick();
    clear_inputs();
    #1;
    checks++;
    if (outs() !== O_IDLE) begin
      errors++;
      $display("FAIL redirect_after: got %b expected %b", outs(), O_IDLE);
    end
    $display("test_redirect_race done");
  endtask

  task automatic test_halt();
    do_reset();
    clear_inputs();
    bus.i_ex_valid = 1'b1;
    bus.i_ex_halt  = 1'b1;
    #1;
    checks++;
    if (outs() !== O_FLUSH) begin
      errors++;
      $display("FAIL halt_edge0: got %b expected %b", outs(), O_FLUSH);
    end
    tick();
    clear_inputs();
    bus.i_mem_req = 1'b1;
    for (int i = 0; i < D; i++) begin
      #1;
      checks++;
      if (outs() !== O_FLUSH) begin
        errors++;
        $display("FAIL halt_drain%0d: got %b expected %b", i, outs(), O_FLUSH);
      end
      tick();
    end
    bus.i_ex_valid    = 1'b1;
    bus.i_ex_redirect = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (outs() !== O_HALTED) begin
        errors++;
        $display("FAIL halt_sticky%0d: got %b expected %b", i, outs(), O_HALTED);
      end
      tick();
    end
    clear_inputs();
    $display("test_halt done");
  endtask

  task automatic test_halt_mem_race();
    do_reset();
    clear_inputs();
    bus.i_ex_valid = 1'b1;
    bus.i_ex_trap  = 1'b1;
    bus.i_mem_req  = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if (outs() !== O_MEMSTL) begin
        errors++;
        $display("FAIL halt_mem_wait%0d: got %b expected %b", i, outs(), O_MEMSTL);
      end
      tick();
    end
    bus.i_mem_ack = 1'b1;
    #1;
    checks++;
    if (outs() !== O_IDLE) begin
      errors++;
      $display("FAIL halt_mem_ack: got %b expected %b", outs(), O_IDLE);
    end
    tick();
    bus.i_mem_req = 1'b0;
    bus.i_mem_ack = 1'b0;
    #1;
    checks++;
    if (outs() !== O_FLUSH) begin
      errors++;
      $display("FAIL halt_mem_enter_drain: got %b expected %b", outs(), O_FLUSH);
    end
    tick();
    clear_inputs();
    #1;
    checks++;
    if (outs() !== O_FLUSH) begin
      errors++;
      $display("FAIL halt_mem_draining: got %b expected %b", outs(), O_FLUSH);
    end
    $display("test_halt_mem_race done");
  endtask

  task automatic test_reset_mid_drain();
    do_reset();
    clear_inputs();
    bus.i_ex_valid = 1'b1;
    bus.i_ex_halt  = 1'b1;
    tick();
    clear_inputs();
    set_load_use(5'd5);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (outs() !== O_IDLE) begin
      errors++;
      $display("FAIL reset_mid_drain_outs: got %b expected %b", outs(), O_IDLE);
    end
    checks++;
    if (bus.o_stall_cycles !== 32'd0) begin
      errors++;
      $display("FAIL reset_mid_drain_count: got %0d expected 0", bus.o_stall_cycles);
    end
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    #1;
    checks++;
    if (outs() !== O_BUBBLE) begin
      errors++;
      $display("FAIL reset_mid_drain_run: got %b expected %b", outs(), O_BUBBLE);
    end
    tick();
    clear_inputs();
    #1;
    checks++;
    if (outs() !== O_IDLE) begin
      errors++;
      $display("FAIL reset_mid_drain_idle: got %b expected %b", outs(), O_IDLE);
    end
    $display("test_reset_mid_drain done");
  endtask

  task automatic test_random();
    logic [6:0] exp;
    logic [31:0] exp_cnt;
    do_reset();
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 59) == 0) do_reset();
      bus.i_id_valid    = ($urandom_range(0, 3) != 0);
      bus.i_id_rs1_addr = 5'($urandom_range(0, 3));
      bus.i_id_rs2_addr = 5'($urandom_range(0, 3));
      bus.i_id_rs1_used = 1'($urandom_range(0, 1));
      bus.i_id_rs2_used = 1'($urandom_range(0, 1));
      bus.i_ex_valid    = ($urandom_range(0, 3) != 0);
      bus.i_ex_mem_read = 1'($urandom_range(0, 1));
      bus.i_ex_rd_addr  = 5'($urandom_range(0, 3));
      bus.i_ex_redirect = ($urandom_range(0, 7) == 0);
      bus.i_ex_halt     = ($urandom_range(0, 39) == 0);
      bus.i_ex_trap     = ($urandom_range(0, 39) == 0);
      bus.i_mem_req     = ($urandom_range(0, 2) == 0);
      bus.i_mem_ack     = 1'($urandom_range(0, 1));
      #1;
      exp     = model_out();
      exp_cnt = PERF ? m_stalls : 32'd0;
      checks++;
      if (outs() !== exp) begin
        errors++;
        $display("FAIL random_outs cycle %0d: got %b expected %b", n, outs(), exp);
      end
      checks++;
      if (bus.o_stall_cycles !== exp_cnt) begin
        errors++;
        $display("FAIL random_count cycle %0d: got %0d expected %0d", n, bus.o_stall_cycles, exp_cnt);
      end
      checks++;
      if (bus.o_idex_stall_thru && bus.o_idex_stall_kill) begin
        errors++;
        $display("FAIL random_thru_kill cycle %0d: got both 1 expected at most one", n);
      end
      $display("rnd %0d phase=%0d outs=%b stalls=%0d", n, m_phase, outs(), bus.o_stall_cycles);
      tick();
    end
    clear_inputs();
    $display("test_random done");
  endtask

  initial begin
    model_reset();
    clear_inputs();
    test_reset();
    test_load_use();
    test_mem_wait();
    test_redirect_race();
    test_halt();
    test_halt_mem_race();
    test_reset_mid_drain();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
